// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared display types and constants for the BCD converter
package display_pkg;

    localparam int DIGIT_W = 4;
    localparam int BCD_MAX = 9999;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;
    typedef bcd_digit_t [3:0] bcd4_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } bcd_conv_state_t;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit correction: add 3 when the digit is 5 or more
module bcd_add3
    import display_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= DIGIT_W'(5)) begin
            digit_out = digit_in + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bcd_converter.sv
// rtl/bcd_converter.sv - sequential shift-and-add-3 binary to four-digit BCD converter
module bcd_converter
    import display_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic [3:0]       hundreds,
    output logic [3:0]       thousands
);

    localparam int CNT_W = $clog2(BIN_W);
    localparam int SCR_W = DIGITS * DIGIT_W;

    bcd_conv_state_t  state_q, state_d;
    logic [BIN_W-1:0] operand_q, operand_d;
    logic [SCR_W-1:0] scratch_q, scratch_d;
    logic [SCR_W-1:0] scratch_adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_ovf_q, pend_ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    bcd4_t            digits_q, digits_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_in  (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .digit_out (scratch_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_comb begin
        state_d    = state_q;
        operand_d  = operand_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        pend_ovf_d = pend_ovf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        digits_d   = digits_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Out-of-range inputs saturate so the display shows 9999.
                    if (bin > BIN_W'(BCD_MAX)) begin
                        operand_d  = BIN_W'(BCD_MAX);
                        pend_ovf_d = 1'b1;
                    end else begin
                        operand_d  = bin;
                        pend_ovf_d = 1'b0;
                    end
                    scratch_d = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_CONV;
                end
            end
            ST_CONV: begin
                scratch_d = {scratch_adj[SCR_W-2:0], operand_q[BIN_W-1]};
                operand_d = {operand_q[BIN_W-2:0], 1'b0};
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    digits_d = scratch_d[4*DIGIT_W-1:0];
                    ovf_d    = pend_ovf_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            operand_q  <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            pend_ovf_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            digits_q   <= '0;
        end else begin
            state_q    <= state_d;
            operand_q  <= operand_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            pend_ovf_q <= pend_ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            digits_q   <= digits_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign ones      = digits_q[0];
    assign tens      = digits_q[1];
    assign hundreds  = digits_q[2];
    assign thousands = digits_q[3];

endmodule

// File: tb/tb_bcd_converter.sv
// tb/tb_bcd_converter.sv - self-checking bench for bcd_converter
module tb_bcd_converter;

    localparam int BIN_W = 14;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [BIN_W-1:0] bin = '0;
    logic             busy, done, overflow;
    logic [3:0]       ones, tens, hundreds, thousands;

    int n_cmp  = 0;
    int n_fail = 0;
    logic check_en = 1'b0;

    bcd_converter #(.BIN_W(BIN_W), .DIGITS(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a conversion takes BIN_W cycles; the result is plain decimal arithmetic.
    logic        exp_busy = 1'b0, exp_done = 1'b0, exp_ovf = 1'b0;
    logic [15:0] exp_bcd = '0;
    int          remaining = 0;
    int          pend_val = 0;
    logic        pend_ovf = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            exp_busy = 1'b0; exp_done = 1'b0; exp_ovf = 1'b0;
            exp_bcd = '0; remaining = 0;
        end else begin
            exp_done = 1'b0;
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    exp_busy = 1'b0;
                    exp_done = 1'b1;
                    exp_bcd  = to_bcd(pend_val);
                    exp_ovf  = pend_ovf;
                end
            end else if (start) begin
                pend_ovf  = (int'(bin) > 9999);
                pend_val  = pend_ovf ? 9999 : int'(bin);
                remaining = BIN_W;
                exp_busy  = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            check("overflow", 32'(overflow), 32'(exp_ovf));
            check("digits", 32'({thousands, hundreds, tens, ones}), 32'(exp_bcd));
            check("busy_done_excl", 32'(busy & done), 32'd0);
        end
    end

    task automatic wait_done(input string name, output int busy_cycles);
        int k;
        busy_cycles = 0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) break;
            if (busy) busy_cycles++;
        end
        if (k == 40) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: no done within 40 cycles", name);
        end
    endtask

    task automatic run_one(input string name, input int v, input logic [15:0] lit_bcd, input logic lit_ovf);
        int bc;
        @(negedge clk);
        bin = BIN_W'(v); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(name, bc);
        check({name, "_bcd"}, 32'({thousands, hundreds, tens, ones}), 32'(lit_bcd));
        check({name, "_ovf"}, 32'(overflow), 32'(lit_ovf));
        check({name, "_busy_len"}, 32'(bc + 1), 32'(BIN_W));
    endtask

    initial begin
        int bc, dones, gap;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_en = 1'b1;
        reset_n = 1'b1;
        check("reset_digits", 32'({thousands, hundreds, tens, ones}), 32'h0);
        check("reset_busy", 32'(busy), 32'd0);

        run_one("zero", 0, 16'h0000, 1'b0);
        run_one("v1234", 1234, 16'h1234, 1'b0);
        run_one("v9999", 9999, 16'h9999, 1'b0);
        run_one("v10000", 10000, 16'h9999, 1'b1);
        run_one("v16383", 16383, 16'h9999, 1'b1);

        // Start pulsed mid-conversion must be ignored.
        @(negedge clk);
        bin = 14'd5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        bin = 14'd42; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", bc);
        check("ignore_bcd", 32'({thousands, hundreds, tens, ones}), 32'h5678);
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("ignore_no_second", 32'(dones), 32'd0);

        // Start held high: back-to-back conversions every BIN_W+1 cycles.
        @(negedge clk);
        bin = 14'd7; start = 1'b1;
        wait_done("held7", bc);
        check("held7_bcd", 32'({thousands, hundreds, tens, ones}), 32'h0007);
        bin = 14'd80;
        gap = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); gap++;
            if (done) break;
        end
        check("held80_gap", 32'(gap), 32'(BIN_W + 1));
        check("held80_bcd", 32'({thousands, hundreds, tens, ones}), 32'h0080);
        bin = 14'd905;
        gap = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); gap++;
            if (done) break;
        end
        start = 1'b0;
        check("held905_gap", 32'(gap), 32'(BIN_W + 1));
        check("held905_bcd", 32'({thousands, hundreds, tens, ones}), 32'h0905);
        repeat (20) @(negedge clk);

        // Reset in the middle of a conversion aborts it.
        bin = 14'd4321; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_bcd", 32'({thousands, hundreds, tens, ones}), 32'h0);
        check("abort_busy", 32'(busy), 32'd0);
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_one("v4321", 4321, 16'h4321, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
